morph_program_sequencer: RTL and testbench
==========================================

MORPH_PROGRAM_SEQUENCER -- requirements
Module: MorphProgramSequencer

Interface
REQ-001 SHALL have parameters: ImageWidth, default 8, image row width in pixels; ImageHeight, default 4, image row count; ProgramLength, default 4, instruction slots; PcWidth, default 2, program counter width, with 2**PcWidth >= ProgramLength.
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  run request; program  in  16*ProgramLength  instruction slots, slot k at [16k+15:16k]; imageIn  in  ImageWidth*ImageHeight  source image.
REQ-004 SHALL have ports: imageAcc  in  ImageWidth*ImageHeight  processor accumulator; image  out  ImageWidth*ImageHeight  latched source image to processor.
REQ-005 SHALL have ports: ce  out  1  processor clock enable; procRst  out  1  processor clear, active-high; el  out  9; morphOp  out  3; morphInSelect  out  1; logicOp  out  3.
REQ-006 SHALL have ports: pc  out  PcWidth  current slot; busy  out  1; done  out  1  one-cycle completion pulse; result  out  ImageWidth*ImageHeight  captured accumulator.

Function
REQ-007 Instruction format SHALL be [15:7] el, [6:4] morphOp, [3] morphInSelect, [2:0] logicOp.
REQ-008 FSM SHALL have states IDLE, LOAD, RUN, DRAIN, DONE.
REQ-009 IDLE: start=1 at a rising edge SHALL latch program and imageIn, clear pc to 0, and enter LOAD; start=0 SHALL leave the FSM in IDLE.
REQ-010 LOAD SHALL last one cycle with procRst=1 and ce=0, then enter RUN.
REQ-011 RUN SHALL drive ce=1 and the fields of latched slot pc for one cycle per instruction, incrementing pc each cycle.
REQ-012 RUN SHALL enter DRAIN after issuing slot ProgramLength-1; pc SHALL not wrap past ProgramLength-1.
REQ-013 DRAIN SHALL last one cycle with ce=0 and SHALL capture imageAcc into result at its closing edge.
REQ-014 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-015 Start-to-done latency SHALL be ProgramLength+3 cycles for a full program: start edge, LOAD, N RUN cycles, DRAIN, DONE.
REQ-016 busy SHALL be 1 in LOAD, RUN, DRAIN and DONE, and 0 in IDLE.
REQ-017 start SHALL be ignored while busy=1; a start sampled in DONE SHALL have no effect.
REQ-018 A change of program or imageIn while busy=1 SHALL not affect the run in progress.
REQ-019 Outside RUN, el, morphOp, morphInSelect and logicOp SHALL be 0.
REQ-020 image SHALL hold the latched image from LOAD until the next accepted start.
REQ-021 result SHALL hold its value until the next DRAIN capture.

Reset
REQ-022 rst=0 SHALL, asynchronously and at any time including mid-run, force: state IDLE; pc=0; busy=0; done=0; ce=0; procRst=0; all instruction outputs 0; image=0; result=0.
REQ-023 An interrupted run SHALL produce no done pulse.
REQ-024 After rst returns to 1, the first start SHALL be accepted at the next rising edge.

Configuration
REQ-025 With macro MORPH_SEQ_HALT_EN defined, an issued slot whose morphOp=3'b111 SHALL be a HALT:
- ce=0 in that cycle;
- its fields are not driven;
- the FSM goes directly to DRAIN;
- latency becomes k+3 cycles, where k is the HALT slot index.
REQ-026 Without MORPH_SEQ_HALT_EN, morphOp=3'b111 SHALL be passed through as an ordinary instruction, and all ProgramLength slots SHALL always run.

Verification
REQ-027 Reset-mid-RUN: drive rst=0 while pc=2 -> immediately busy=0, ce=0, result=0; no done pulse follows.
REQ-028 Normal run: program slots el=9'b010111010/morphOp=3'b010/morphInSelect=1/logicOp=0, then el=9'b000001000/morphOp=3'b001; pulse start -> procRst one cycle, ce=1 for 4 cycles, pc sequence 0,1,2,3, done at start+7.
REQ-029 Result capture: model imageAcc=32'hDEADBEEF during DRAIN -> result=32'hDEADBEEF after done, held through IDLE.
REQ-030 Busy start: pulse start again at pc=1 and change program at the same time -> no restart, original instructions issued, exactly one done.
REQ-031 HALT with MORPH_SEQ_HALT_EN: slot1 morphOp=3'b111 -> ce=1 only in slot 0, done at start+4. Without the macro: slot1 issued with morphOp=3'b111, done at start+7.
REQ-032 Back-to-back runs: start asserted the cycle after done -> accepted, second run with fresh imageIn latched.

Source files
------------

// File: rtl/morph_program_sequencer.sv
// Sequencer that steps a latched instruction program into a morphology processor.
// Optional HALT opcode (morphOp=3'b111 ends the program early) is enabled by defining MORPH_SEQ_HALT_EN.
module morph_program_sequencer #(
  parameter int ImageWidth    = 8,
  parameter int ImageHeight   = 4,
  parameter int ProgramLength = 4,
  parameter int PcWidth       = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [16*ProgramLength-1:0]        prog,
  input  logic [ImageWidth*ImageHeight-1:0]  imageIn,
  input  logic [ImageWidth*ImageHeight-1:0]  imageAcc,
  output logic [ImageWidth*ImageHeight-1:0]  image,
  output logic                               ce,
  output logic                               procRst,
  output logic [8:0]                         el,
  output logic [2:0]                         morphOp,
  output logic                               morphInSelect,
  output logic [2:0]                         logicOp,
  output logic [PcWidth-1:0]                 pc,
  output logic                               busy,
  output logic                               done,
  output logic [ImageWidth*ImageHeight-1:0]  result
);

  localparam int PixBits = ImageWidth * ImageHeight;
  localparam logic [PcWidth-1:0] LastPc = PcWidth'(ProgramLength - 1);
`ifdef MORPH_SEQ_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                      state_r, state_s;
  logic [PcWidth-1:0]          pc_r, pc_s;
  logic [16*ProgramLength-1:0] prog_r;
  logic [PixBits-1:0]          image_r, result_r;
  logic                        ce_r, proc_rst_r, busy_r, done_r;
  logic [15:0]                 instr_r;
  logic                        ce_s, proc_rst_s, busy_s, done_s;
  logic [15:0]                 instr_s;

  function automatic logic [15:0] slot_of(input logic [16*ProgramLength-1:0] p,
                                          input logic [PcWidth-1:0] k);
    slot_of = p[{k, 4'b0000} +: 16];
  endfunction

  function automatic logic is_halt(input logic [15:0] ins);
    is_halt = HaltEn && (ins[6:4] == 3'b111);
  endfunction

  // State register and program counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      pc_r    <= '0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
    end
  end

  // Next-state logic; a HALT slot is never issued, the FSM drains in its place.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    case (state_r)
      IDLE: begin
        state_s = start ? LOAD : IDLE;
        pc_s    = start ? '0 : pc_r;
      end
      LOAD: begin
        state_s = is_halt(slot_of(prog_r, pc_r)) ? DRAIN : RUN;
      end
      RUN: begin
        if (pc_r == LastPc) begin
          state_s = DRAIN;
        end else if (is_halt(slot_of(prog_r, pc_r + PcWidth'(1)))) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
          pc_s    = pc_r + PcWidth'(1);
        end
      end
      DRAIN:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: begin
        state_s = IDLE;
        pc_s    = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    ce_s       = 1'b0;
    proc_rst_s = 1'b0;
    instr_s    = 16'h0000;
    busy_s     = (state_s != IDLE);
    done_s     = (state_s == DONE);
    case (state_s)
      LOAD: proc_rst_s = 1'b1;
      RUN: begin
        ce_s    = 1'b1;
        instr_s = slot_of(prog_r, pc_s);
      end
      default: begin
        ce_s       = 1'b0;
        proc_rst_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_r       <= 1'b0;
      proc_rst_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      instr_r    <= 16'h0000;
    end else begin
      ce_r       <= ce_s;
      proc_rst_r <= proc_rst_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      instr_r    <= instr_s;
    end
  end

  // Program/image latch on an accepted start; accumulator capture at the end of DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prog_r   <= '0;
      image_r  <= '0;
      result_r <= '0;
    end else begin
      if (state_r == IDLE && start) begin
        prog_r  <= prog;
        image_r <= imageIn;
      end
      if (state_r == DRAIN) begin
        result_r <= imageAcc;
      end
    end
  end

  assign image         = image_r;
  assign ce            = ce_r;
  assign procRst       = proc_rst_r;
  assign el            = instr_r[15:7];
  assign morphOp       = instr_r[6:4];
  assign morphInSelect = instr_r[3];
  assign logicOp       = instr_r[2:0];
  assign pc            = pc_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign result        = result_r;

endmodule

// File: tb/tb_morph_program_sequencer.sv
// Scoreboard bench for morph_program_sequencer: expected results queued at start, popped on done.
module tb_morph_program_sequencer;

`ifdef MORPH_SEQ_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [63:0] prog = 64'h0;
  logic [31:0] imageIn = 32'h0;
  logic [31:0] imageAcc = 32'h0;
  logic [31:0] image;
  logic        ce, procRst, morphInSelect, busy, done;
  logic [8:0]  el;
  logic [2:0]  morphOp, logicOp;
  logic [1:0]  pc;
  logic [31:0] result;

  int n_vec = 0;
  int n_miscmp = 0;
  int n_done = 0;
  int n_runs_exp = 0;
  logic [31:0] sb_q[$];

  morph_program_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .prog(prog), .imageIn(imageIn),
    .imageAcc(imageAcc), .image(image), .ce(ce), .procRst(procRst), .el(el),
    .morphOp(morphOp), .morphInSelect(morphInSelect), .logicOp(logicOp),
    .pc(pc), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int run_len(input logic [63:0] p);
    run_len = 4;
    for (int i = 3; i >= 0; i--) begin
      if (HaltEn && p[16*i+4 +: 3] == 3'b111) run_len = i;
    end
  endfunction

  // Scoreboard: every done pulse must retire exactly one queued result.
  always @(posedge clk) begin
    #1;
    if (done) begin
      n_done++;
      chk("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) chk("sb_result", result, sb_q.pop_front());
    end
  end

  task automatic run_prog(input logic [63:0] p, input logic [31:0] img, input logic [31:0] acc,
                          input int poke_pc, input bit start_in_done);
    int n;
    n = run_len(p);
    prog = p;
    imageIn = img;
    start = 1'b1;
    sb_q.push_back(acc);
    n_runs_exp++;
    tick();
    start = 1'b0;
    imageIn = ~img;
    chk("load_procrst", procRst, 1'b1);
    chk("load_ce", ce, 1'b0);
    chk("load_busy", busy, 1'b1);
    chk("load_image", image, img);
    for (int i = 0; i < n; i++) begin
      imageAcc = acc ^ 32'hFFFF_0000;
      tick();
      chk("run_ce", ce, 1'b1);
      chk("run_procrst", procRst, 1'b0);
      chk("run_pc", pc, i);
      chk("run_el", el, p[16*i+7 +: 9]);
      chk("run_op", morphOp, p[16*i+4 +: 3]);
      chk("run_sel", morphInSelect, p[16*i+3]);
      chk("run_lop", logicOp, p[16*i +: 3]);
      chk("run_image", image, img);
      if (i == poke_pc) begin
        start = 1'b1;
        prog = ~p;
      end else begin
        start = 1'b0;
      end
    end
    tick();
    start = 1'b0;
    chk("drain_ce", ce, 1'b0);
    chk("drain_instr", {el, morphOp, morphInSelect, logicOp}, 16'h0000);
    chk("drain_busy", busy, 1'b1);
    chk("drain_done", done, 1'b0);
    imageAcc = acc;
    tick();
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b1);
    chk("done_ce", ce, 1'b0);
    imageAcc = ~acc;
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_result", result, acc);
    chk("idle_image", image, img);
  endtask

  localparam logic [63:0] P1 = {16'hA5C3, 16'h1234, {9'b000001000, 3'b001, 1'b0, 3'b000},
                                {9'b010111010, 3'b010, 1'b1, 3'b000}};
  localparam logic [63:0] P2 = {16'h0F0F, 16'h7E21, 16'hC3A4, 16'h5A5D};
  localparam logic [63:0] P3 = {16'h1111, 16'h2222, {9'h0AA, 3'b111, 1'b0, 3'b101}, 16'hBEE6};

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_ce", ce, 1'b0);
    chk("rst_pc", pc, 2'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_image", image, 32'h0);
    rst = 1'b1;
    tick();

    run_prog(P1, 32'h1357_9BDF, 32'hDEAD_BEEF, -1, 1'b0);
    repeat (3) tick();
    chk("held_result", result, 32'hDEAD_BEEF);
    chk("held_busy", busy, 1'b0);

    // Busy start with program change, start in DONE, then back-to-back runs
    run_prog(P2, 32'hCAFE_F00D, 32'h0BAD_C0DE, 1, 1'b1);
    run_prog(P3, 32'h8765_4321, 32'h600D_1DEA, -1, 1'b0);
    run_prog(P1, 32'h0246_8ACE, 32'h1234_5678, -1, 1'b0);

    // Reset in the middle of RUN
    prog = P2;
    imageIn = 32'hFACE_B00C;
    imageAcc = 32'h7777_7777;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("mid_pc", pc, 2'd2);
    rst = 1'b0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_ce", ce, 1'b0);
    chk("mid_result", result, 32'h0);
    chk("mid_pc0", pc, 2'd0);
    chk("mid_image", image, 32'h0);
    chk("mid_instr", {el, morphOp, morphInSelect, logicOp}, 16'h0000);
    repeat (8) tick();
    rst = 1'b1;
    run_prog(P2, 32'h3C3C_A5A5, 32'h0F1E_2D3C, -1, 1'b0);
    repeat (3) tick();

    chk("done_count", n_done, n_runs_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
